// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the EXE-stage multiply sequencer.
//   - ALU operation encodings used on the shared ALU operand mux
//   - FSM state encoding of the sequencer
//   - default datapath width
package alu_mul_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] ALU_OP_AND = 2'b00;
    localparam logic [1:0] ALU_OP_ADD = 2'b01;
    localparam logic [1:0] ALU_OP_SUB = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

endpackage : alu_mul_sequencer_pkg

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the EXE-stage ALU for its additions.
// One iteration per cycle in which the pipeline does not need the ALU; the
// pipeline always wins, so a pipeline request simply stalls the multiply.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       multiply request, honoured only when idle
//   op_a, op_b  multiplicand / multiplier, captured on accepted start
//   pipe_req    pipeline needs the ALU this cycle (highest priority)
//   alu_result  result of the shared ALU
//   mul_grant   1 = ALU operands come from this block
//   alu_a/alu_b ALU operands (zero when not granted)
//   alu_op      ALU operation (zero when not granted)
//   busy        multiply in progress (RUN or DONE)
//   done        one-cycle pulse, product valid
//   product     low WIDTH bits of op_a*op_b, held until the next completion
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             pipe_req,
    input  logic [WIDTH-1:0] alu_result,
    output logic             mul_grant,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0] acc_next_s;
    logic             grant_s;

    // Grant is combinational so the pipeline can reclaim the ALU in the same cycle.
    always_comb begin
        grant_s = (state_q == ST_RUN) && !pipe_req;
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        // Partial sum after this iteration; only add when the multiplier bit is set.
        acc_next_s = mplier_q[0] ? alu_result : acc_q;

        case (state_q)
            ST_IDLE: begin
                // Acceptance does not use the ALU, so pipe_req is irrelevant here.
                if (start) begin
                    state_d  = ST_RUN;
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (grant_s) begin
                    acc_d    = acc_next_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d   = ST_DONE;
                        product_d = acc_next_s;
                    end else begin
                        state_d   = ST_RUN;
                    end
                end else begin
                    // Pipeline owns the ALU: freeze everything.
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Output decode: ALU operands are driven only while granted, zero otherwise.
    always_comb begin
        mul_grant = grant_s;
        if (grant_s) begin
            alu_a  = acc_q;
            alu_b  = mcand_q;
            alu_op = ALU_OP_ADD;
        end else begin
            alu_a  = '0;
            alu_b  = '0;
            alu_op = ALU_OP_AND;
        end
        busy    = (state_q == ST_RUN) || (state_q == ST_DONE);
        done    = (state_q == ST_DONE);
        product = product_q;
    end

endmodule : alu_mul_sequencer

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: expected products are pushed when a
// start is driven and popped when done is seen.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        pipe_req;
    logic [15:0] alu_result;
    logic        mul_grant;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_product = 16'h0000;

    alu_mul_sequencer #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .pipe_req   (pipe_req),
        .alu_result (alu_result),
        .mul_grant  (mul_grant),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .busy       (busy),
        .done       (done),
        .product    (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared EXE-stage ALU model.
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_a & alu_b;
            2'b01:   alu_result = alu_a + alu_b;
            2'b10:   alu_result = alu_a - alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    // Run one multiply; optionally stall, re-assert start mid-run, or raise pipe_req on accept.
    task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input int stall_at,
                          input int stall_len, input int restart_at, input bit preq0,
                          input string name);
        logic [15:0] exp_p;
        logic [15:0] prod_exp;
        int lat;
        int grants;
        bit got;
        prod_exp = a * b;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1; pipe_req = preq0;
        exp_q.push_back(prod_exp);
        @(posedge clk);
        #1;
        start = 1'b0; pipe_req = 1'b0;
        lat = 1; grants = 0; got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            pipe_req = (i >= stall_at) && (i < stall_at + stall_len);
            if (i == restart_at) begin
                start = 1'b1; op_a = 16'd9; op_b = 16'd9;
            end else begin
                start = 1'b0;
            end
            #1;
            if (i == 2) begin
                total++;
                if (product !== last_product) begin
                    bad++;
                    $display("FAIL %s_hold: product=%h expected %h", name, product, last_product);
                end
            end
            if (mul_grant) grants++;
            if (pipe_req) begin
                total++;
                if (mul_grant !== 1'b0 || alu_op !== 2'b00 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_stall: grant=%b op=%b busy=%b expected 0 00 1",
                             name, mul_grant, alu_op, busy);
                end
            end
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        start = 1'b0; pipe_req = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_timeout: no done within 200 cycles", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            exp_p = exp_q.pop_front();
            if (product !== exp_p) begin
                bad++;
                $display("FAIL %s_product: got %h expected %h", name, product, exp_p);
            end
            last_product = exp_p;
            total++;
            if (lat !== 17 + stall_len) begin
                bad++;
                $display("FAIL %s_latency: got %0d expected %0d", name, lat, 17 + stall_len);
            end
            total++;
            if (grants !== 16) begin
                bad++;
                $display("FAIL %s_grants: got %0d expected 16", name, grants);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || mul_grant !== 1'b0 || alu_a !== 16'h0000 ||
            alu_b !== 16'h0000 || alu_op !== 2'b00 || product !== 16'h0000) begin
            bad++;
            $display("FAIL %s: done=%b busy=%b grant=%b a=%h b=%h op=%b prod=%h expected all 0",
                     name, done, busy, mul_grant, alu_a, alu_b, alu_op, product);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; pipe_req = 1'b0; op_a = 16'h0000; op_b = 16'h0000;
        #1;
        check_zero_outputs("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_zero_outputs("after_release");
    endtask

    task automatic test_basic();
        do_mul(16'd3, 16'd5, -1, 0, -1, 1'b0, "mul_3x5");
    endtask

    task automatic test_patterns();
        do_mul(16'd300, 16'd300, -1, 0, -1, 1'b0, "mul_300x300");
        do_mul(16'h0100, 16'h0100, -1, 0, -1, 1'b0, "mul_wrap_zero");
        do_mul(16'hFFFE, 16'd7, -1, 0, -1, 1'b0, "mul_neg2x7");
        do_mul(16'hFFFF, 16'hFFFF, -1, 0, -1, 1'b0, "mul_all_ones");
        do_mul(16'h0000, 16'h1234, -1, 0, -1, 1'b0, "mul_zero");
        for (int k = 0; k < 3; k++) begin
            do_mul(16'($urandom), 16'($urandom), -1, 0, -1, 1'b0, "mul_random");
        end
    endtask

    task automatic test_stall();
        do_mul(16'd3, 16'd5, 5, 4, -1, 1'b0, "stall_4");
    endtask

    task automatic test_idle_priority();
        do_mul(16'd6, 16'd7, -1, 0, -1, 1'b1, "start_with_pipe_req");
    endtask

    task automatic test_back_to_back();
        int extra;
        do_mul(16'd3, 16'd5, -1, 0, 4, 1'b0, "ignore_restart");
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            #1;
            if (done) extra++;
        end
        total++;
        if (extra !== 0 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL extra_done: pulses=%0d pending=%0d expected 0 0", extra, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        op_a = 16'd3; op_b = 16'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero_outputs("reset_mid");
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done) seen++;
        end
        reset = 1'b1;
        last_product = 16'h0000;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (done) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_no_done: pulses=%0d expected 0", seen);
        end
        do_mul(16'd2, 16'd2, -1, 0, -1, 1'b0, "after_reset_2x2");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_stall();
        test_idle_priority();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_mul_sequencer
